tlu_handshake_ctrl: RTL and testbench

// - Trigger-acceptance core of the TLU trigger path. It sits between the EUDET-style TLU cable (TLU_TRIGGER/TLU_BUSY/TLU_CLOCK),
//   a local trigger input, and the readout FIFO.
// - Accepts one trigger at a time and runs the selected handshake, clocking out the TLU trigger ID where the mode requires it.
// - Presents one 32-bit trigger word at a time on a first-word-fall-through FIFO-style read port.

---
 rtl/tlu_pkg.sv | 22 ++
 rtl/tlu_handshake_ctrl_if.sv | 35 +++
 rtl/tlu_handshake_ctrl_sync2.sv | 19 +
 rtl/tlu_handshake_ctrl.sv | 155 +++++++++++++++
 tb/tb_tlu_handshake_ctrl.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tlu_pkg.sv
// Shared definitions for the TLU trigger-acceptance path: trigger modes,
// handshake FSM states and the trigger-word marker.
package tlu_pkg;

  typedef enum logic [1:0] {
    MODE_EXT        = 2'd0,
    MODE_TLU_NOHS   = 2'd1,
    MODE_TLU_SIMPLE = 2'd2,
    MODE_TLU_DATA   = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_LOW,
    SHIFT
  } state_t;

  localparam logic        WORD_MARKER = 1'b1;
  localparam int unsigned MARKER_BIT  = 31;

endpackage

// File: rtl/tlu_handshake_ctrl_if.sv
// Trigger, TLU cable and FIFO read-port signals of tlu_handshake_ctrl,
// bundled with master (environment) and slave (controller) views.
interface tlu_handshake_ctrl_if;
  import tlu_pkg::*;

  mode_t       TRIGGER_MODE;
  logic        TRIGGER_ENABLE;
  logic        TRIGGER;
  logic        TRIGGER_VETO;
  logic        TLU_TRIGGER;
  logic        TLU_RESET;
  logic        TLU_BUSY;
  logic        TLU_CLOCK;
  logic        TRIGGER_ACCEPTED_FLAG;
  logic        TRIGGER_ACKNOWLEDGE;
  logic        FIFO_READ;
  logic        FIFO_EMPTY;
  logic [31:0] FIFO_DATA;
  logic [31:0] TRIGGER_COUNTER;

  modport master (
    output TRIGGER_MODE, TRIGGER_ENABLE, TRIGGER, TRIGGER_VETO,
    output TLU_TRIGGER, TLU_RESET, TRIGGER_ACKNOWLEDGE, FIFO_READ,
    input  TLU_BUSY, TLU_CLOCK, TRIGGER_ACCEPTED_FLAG,
    input  FIFO_EMPTY, FIFO_DATA, TRIGGER_COUNTER
  );

  modport slave (
    input  TRIGGER_MODE, TRIGGER_ENABLE, TRIGGER, TRIGGER_VETO,
    input  TLU_TRIGGER, TLU_RESET, TRIGGER_ACKNOWLEDGE, FIFO_READ,
    output TLU_BUSY, TLU_CLOCK, TRIGGER_ACCEPTED_FLAG,
    output FIFO_EMPTY, FIFO_DATA, TRIGGER_COUNTER
  );

endinterface

// File: rtl/tlu_handshake_ctrl_sync2.sv
// Two-flop synchronizer for asynchronous TLU cable inputs.
module tlu_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/tlu_handshake_ctrl.sv
// Trigger-acceptance core: accepts one trigger at a time, runs the selected
// TLU handshake, shifts in the TLU trigger ID and holds one trigger word.
module tlu_handshake_ctrl
  import tlu_pkg::*;
#(
  parameter int unsigned DIVISOR         = 8,
  parameter int unsigned TRIGGER_ID_BITS = 15
) (
  input logic                 BUS_CLK,
  input logic                 BUS_RST,
  tlu_handshake_ctrl_if.slave bus
);
  localparam int unsigned HALF  = DIVISOR / 2;
  localparam int unsigned DIV_W = $clog2(DIVISOR);
  localparam int unsigned BIT_W = $clog2(TRIGGER_ID_BITS + 1);

  state_t state_q, state_d;
  mode_t  mode_q, mode_in;

  logic trig_sync, trig_sync_d, tlu_rst_sync, ext_d;
  logic ext_src, ext_edge, tlu_edge, src_edge, accept, ack_seen, flag;
  logic load_ext, load_id, busy_set, busy_clr;
  logic busy_q, ack_q, fifo_empty_q;
  logic last_high, last_low, shift_done;

  logic [DIV_W-1:0]           div_cnt;
  logic [BIT_W-1:0]           bit_cnt;
  logic [TRIGGER_ID_BITS-1:0] id_q;
  logic [31:0]                fifo_data_q, count_q, id_word;

  tlu_sync2 u_sync_trig (.clk(BUS_CLK), .rst(BUS_RST), .d(bus.TLU_TRIGGER), .q(trig_sync));
  tlu_sync2 u_sync_rst  (.clk(BUS_CLK), .rst(BUS_RST), .d(bus.TLU_RESET),   .q(tlu_rst_sync));

  assign mode_in  = bus.TRIGGER_MODE;
  assign ext_src  = bus.TRIGGER & ~bus.TRIGGER_VETO;
  assign ext_edge = ext_src & ~ext_d;
  assign tlu_edge = trig_sync & ~trig_sync_d;
  assign src_edge = (mode_in == MODE_EXT) ? ext_edge : tlu_edge;
  // A full word buffer blocks acceptance, which also keeps BUSY low toward the TLU.
  assign accept   = (state_q == IDLE) & src_edge & bus.TRIGGER_ENABLE & fifo_empty_q;
  assign ack_seen = ack_q | bus.TRIGGER_ACKNOWLEDGE;

  assign last_high  = (div_cnt == DIV_W'(HALF - 1));
  assign last_low   = (div_cnt == DIV_W'(DIVISOR - 1));
  assign shift_done = (state_q == SHIFT) & last_low & (bit_cnt == BIT_W'(TRIGGER_ID_BITS - 1));

  always_comb begin
    id_word = '0;
    id_word[TRIGGER_ID_BITS-1:0] = id_q;
    id_word[MARKER_BIT] = WORD_MARKER;
  end

  always_comb begin
    state_d  = state_q;
    flag     = 1'b0;
    load_ext = 1'b0;
    load_id  = 1'b0;
    busy_set = 1'b0;
    busy_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          flag     = 1'b1;
          load_ext = (mode_in != MODE_TLU_DATA);
          busy_set = (mode_in == MODE_TLU_SIMPLE) || (mode_in == MODE_TLU_DATA);
          state_d  = (mode_in == MODE_TLU_DATA) ? WAIT_LOW : WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_seen) begin
          if (mode_q == MODE_TLU_SIMPLE) begin
            state_d = WAIT_LOW;
          end else begin
            state_d  = IDLE;
            busy_clr = 1'b1;
          end
        end
      end
      WAIT_LOW: begin
        if (!trig_sync) begin
          if (mode_q == MODE_TLU_SIMPLE) begin
            state_d  = IDLE;
            busy_clr = 1'b1;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (shift_done) begin
          load_id = 1'b1;
          state_d = WAIT_ACK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state_q      <= IDLE;
      mode_q       <= MODE_EXT;
      trig_sync_d  <= 1'b0;
      ext_d        <= 1'b0;
      ack_q        <= 1'b0;
      busy_q       <= 1'b0;
      count_q      <= '0;
      fifo_empty_q <= 1'b1;
      fifo_data_q  <= '0;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      id_q         <= '0;
    end else begin
      state_q     <= state_d;
      trig_sync_d <= trig_sync;
      ext_d       <= ext_src;
      if (accept) mode_q <= mode_in;
      ack_q <= (state_q == IDLE) ? (accept & bus.TRIGGER_ACKNOWLEDGE) : ack_seen;

      if (busy_set)      busy_q <= 1'b1;
      else if (busy_clr) busy_q <= 1'b0;

      if (tlu_rst_sync) count_q <= '0;
      else if (accept)  count_q <= count_q + 32'd1;

      if (load_ext) begin
        fifo_data_q  <= {WORD_MARKER, count_q[30:0]};
        fifo_empty_q <= 1'b0;
      end else if (load_id) begin
        fifo_data_q  <= id_word;
        fifo_empty_q <= 1'b0;
      end else if (bus.FIFO_READ && !fifo_empty_q) begin
        fifo_empty_q <= 1'b1;
      end

      // Each period is high phase then low phase; the ID bit is taken at the end of the high phase.
      if (state_q == SHIFT) begin
        div_cnt <= last_low ? '0 : div_cnt + 1'b1;
        if (last_low)  bit_cnt <= bit_cnt + 1'b1;
        if (last_high) id_q <= {trig_sync, id_q[TRIGGER_ID_BITS-1:1]};
      end else begin
        div_cnt <= '0;
        bit_cnt <= '0;
      end
    end
  end

  assign bus.TLU_BUSY              = busy_q;
  assign bus.TLU_CLOCK             = (state_q == SHIFT) && (div_cnt < DIV_W'(HALF));
  assign bus.TRIGGER_ACCEPTED_FLAG = flag;
  assign bus.FIFO_EMPTY            = fifo_empty_q;
  assign bus.FIFO_DATA             = fifo_data_q;
  assign bus.TRIGGER_COUNTER       = count_q;

endmodule

// File: tb/tb_tlu_handshake_ctrl.sv
// Scoreboard bench for tlu_handshake_ctrl: stimulus pushes expected trigger
// words from a counter/ID model; a monitor pops and compares each held word.
module tb_tlu_handshake_ctrl;
  import tlu_pkg::*;

  localparam int unsigned DIV   = 8;
  localparam int unsigned IDB   = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tlu_handshake_ctrl_if bus ();

  tlu_handshake_ctrl #(.DIVISOR(DIV), .TRIGGER_ID_BITS(IDB)) dut (
    .BUS_CLK(clk),
    .BUS_RST(rst),
    .bus    (bus)
  );

  logic ack_follow = 1'b0;
  logic ack_manual = 1'b0;
  assign bus.TRIGGER_ACKNOWLEDGE = ack_follow ? bus.TRIGGER_ACCEPTED_FLAG : ack_manual;

  int unsigned nchk = 0;
  int unsigned nerr = 0;
  int unsigned flag_seen = 0;
  logic [31:0] model_cnt = '0;
  logic [31:0] last_word = '0;
  logic [31:0] exp_q[$];
  bit auto_read = 1'b1;
  bit read_req  = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_busy(input logic v, input string nm);
    for (int i = 0; i < 300 && bus.TLU_BUSY !== v; i++) cyc(1);
    check(nm, 32'(bus.TLU_BUSY), 32'(v));
  endtask

  task automatic wait_flag(input int unsigned target, input string nm);
    for (int i = 0; i < 100 && flag_seen < target; i++) cyc(1);
    check(nm, 32'(flag_seen), 32'(target));
  endtask

  task automatic wait_empty(input string nm);
    for (int i = 0; i < 100 && bus.FIFO_EMPTY !== 1'b1; i++) cyc(1);
    check(nm, 32'(bus.FIFO_EMPTY), 32'd1);
  endtask

  // Reference: modes 0-2 report the pre-increment count, mode 3 the TLU ID.
  task automatic model_accept(input mode_t m, input logic [14:0] id, output logic [31:0] w);
    if (m == MODE_TLU_DATA) w = 32'h8000_0000 | {17'd0, id};
    else                    w = 32'h8000_0000 | (model_cnt & 32'h7FFF_FFFF);
    model_cnt = model_cnt + 32'd1;
    last_word = w;
  endtask

  // TLU side of the data handshake: put ID bit i on the line at the i-th TLU_CLOCK rise.
  task automatic shift_id(input logic [14:0] id, output int unsigned pulses, output int unsigned bad);
    logic prev;
    int unsigned last;
    prev = bus.TLU_CLOCK; pulses = 0; bad = 0; last = 0;
    for (int unsigned t = 1; t <= IDB * DIV + 40; t++) begin
      cyc(1);
      if (bus.TLU_CLOCK && !prev) begin
        if (pulses > 0 && (t - last) != DIV) bad++;
        last = t;
        if (pulses < IDB) bus.TLU_TRIGGER = id[pulses];
        pulses++;
      end
      prev = bus.TLU_CLOCK;
    end
  endtask

  task automatic do_trigger(input mode_t m, input logic [14:0] id, input int unsigned ack_dly);
    int unsigned f0, pulses, bad;
    logic [31:0] w;
    f0 = flag_seen;
    bus.TRIGGER_MODE = m;
    ack_follow = (ack_dly == 0);
    model_accept(m, id, w);
    exp_q.push_back(w);
    if (m == MODE_EXT) begin
      bus.TRIGGER = 1'b1; cyc(2); bus.TRIGGER = 1'b0;
    end else begin
      bus.TLU_TRIGGER = 1'b1;
    end
    wait_flag(f0 + 1, "flag");
    if (m == MODE_TLU_NOHS) bus.TLU_TRIGGER = 1'b0;
    if (m == MODE_TLU_SIMPLE || m == MODE_TLU_DATA) wait_busy(1'b1, "busy_rise");
    if (ack_dly != 0) begin
      cyc(ack_dly);
      if (m == MODE_TLU_SIMPLE || m == MODE_TLU_DATA)
        check("busy_before_ack", 32'(bus.TLU_BUSY), 32'd1);
      ack_manual = 1'b1; cyc(1); ack_manual = 1'b0;
    end
    if (m == MODE_TLU_SIMPLE) begin
      cyc(4);
      check("busy_trig_high", 32'(bus.TLU_BUSY), 32'd1);
      bus.TLU_TRIGGER = 1'b0;
      wait_busy(1'b0, "busy_fall");
    end else if (m == MODE_TLU_DATA) begin
      bus.TLU_TRIGGER = 1'b0;
      shift_id(id, pulses, bad);
      bus.TLU_TRIGGER = 1'b0;
      check("clk_pulses", 32'(pulses), 32'(IDB));
      check("clk_period", 32'(bad), 32'd0);
      check("busy_after_shift", 32'(bus.TLU_BUSY), 32'd0);
    end else begin
      cyc(3);
    end
    check("counter", bus.TRIGGER_COUNTER, model_cnt);
    if (auto_read) wait_empty("drain");
    cyc(2);
  endtask

  task automatic tlu_reset_pulse();
    bus.TLU_RESET = 1'b1; cyc(2); bus.TLU_RESET = 1'b0; cyc(4);
    model_cnt = '0;
    check("tlu_reset_counter", bus.TRIGGER_COUNTER, model_cnt);
  endtask

  initial begin : monitor
    bit held;
    held = 1'b0;
    bus.FIFO_READ = 1'b0;
    forever begin
      @(negedge clk);
      bus.FIFO_READ = 1'b0;
      if (bus.TRIGGER_ACCEPTED_FLAG === 1'b1) flag_seen++;
      if (bus.FIFO_EMPTY !== 1'b0) begin
        held = 1'b0;
      end else begin
        if (!held) begin
          held = 1'b1;
          if (exp_q.size() == 0) begin
            nchk++; nerr++;
            $display("FAIL word_unexpected: got %h, expected no word", bus.FIFO_DATA);
          end else begin
            check("word", bus.FIFO_DATA, exp_q.pop_front());
          end
        end
        if (auto_read || read_req) bus.FIFO_READ = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int unsigned f0, rises;
    logic prev;
    mode_t m;
    bus.TRIGGER_MODE   = MODE_EXT;
    bus.TRIGGER_ENABLE = 1'b1;
    bus.TRIGGER        = 1'b0;
    bus.TRIGGER_VETO   = 1'b0;
    bus.TLU_TRIGGER    = 1'b0;
    bus.TLU_RESET      = 1'b0;
    cyc(3);
    @(negedge clk);
    check("rst_busy",    32'(bus.TLU_BUSY), 32'd0);
    check("rst_tluclk",  32'(bus.TLU_CLOCK), 32'd0);
    check("rst_flag",    32'(bus.TRIGGER_ACCEPTED_FLAG), 32'd0);
    check("rst_empty",   32'(bus.FIFO_EMPTY), 32'd1);
    check("rst_data",    bus.FIFO_DATA, 32'd0);
    check("rst_counter", bus.TRIGGER_COUNTER, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    cyc(3);

    // External triggers, then a vetoed pulse that must be dropped.
    for (int i = 0; i < 3; i++) do_trigger(MODE_EXT, 15'd0, 0);
    f0 = flag_seen;
    bus.TRIGGER_VETO = 1'b1; bus.TRIGGER = 1'b1; cyc(2); bus.TRIGGER = 1'b0; cyc(5);
    bus.TRIGGER_VETO = 1'b0;
    check("veto_flag", 32'(flag_seen), 32'(f0));
    check("veto_counter", bus.TRIGGER_COUNTER, 32'd3);

    // Simple handshake with acknowledge 20 cycles late.
    tlu_reset_pulse();
    do_trigger(MODE_TLU_SIMPLE, 15'd0, 20);

    // Data handshake, ID 5, word left unread.
    tlu_reset_pulse();
    auto_read = 1'b0;
    do_trigger(MODE_TLU_DATA, 15'd5, 0);
    check("held_empty", 32'(bus.FIFO_EMPTY), 32'd0);
    check("held_data", bus.FIFO_DATA, last_word);

    // Second TLU trigger while the word is held: dropped.
    f0 = flag_seen;
    bus.TLU_TRIGGER = 1'b1; cyc(20);
    check("full_flag", 32'(flag_seen), 32'(f0));
    check("full_busy", 32'(bus.TLU_BUSY), 32'd0);
    check("full_data", bus.FIFO_DATA, last_word);
    check("full_counter", bus.TRIGGER_COUNTER, model_cnt);
    bus.TLU_TRIGGER = 1'b0; cyc(4);
    read_req = 1'b1; wait_empty("read_held"); read_req = 1'b0;
    auto_read = 1'b1;
    do_trigger(MODE_TLU_DATA, 15'd6, 0);

    // Bus reset in the middle of ID shifting.
    bus.TRIGGER_MODE = MODE_TLU_DATA; ack_follow = 1'b1; f0 = flag_seen;
    bus.TLU_TRIGGER = 1'b1;
    wait_flag(f0 + 1, "shiftrst_flag");
    wait_busy(1'b1, "shiftrst_busy");
    bus.TLU_TRIGGER = 1'b0;
    rises = 0; prev = 1'b0;
    for (int i = 0; i < 200 && rises < 3; i++) begin
      cyc(1);
      if (bus.TLU_CLOCK && !prev) rises++;
      prev = bus.TLU_CLOCK;
    end
    check("shiftrst_rises", 32'(rises), 32'd3);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("shiftrst_busy_low", 32'(bus.TLU_BUSY), 32'd0);
    check("shiftrst_tluclk",   32'(bus.TLU_CLOCK), 32'd0);
    check("shiftrst_empty",    32'(bus.FIFO_EMPTY), 32'd1);
    check("shiftrst_counter",  bus.TRIGGER_COUNTER, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    model_cnt = '0;
    cyc(3);
    do_trigger(MODE_TLU_DATA, 15'($urandom_range(0, 32767)), 0);

    // Triggers while disabled must be ignored.
    bus.TRIGGER_ENABLE = 1'b0; f0 = flag_seen;
    for (int i = 0; i < 4; i++) begin
      bus.TRIGGER_MODE = mode_t'(i);
      bus.TLU_TRIGGER = 1'b1; bus.TRIGGER = 1'b1; cyc(8);
      bus.TLU_TRIGGER = 1'b0; bus.TRIGGER = 1'b0; cyc(4);
    end
    check("dis_flag",  32'(flag_seen), 32'(f0));
    check("dis_busy",  32'(bus.TLU_BUSY), 32'd0);
    check("dis_empty", 32'(bus.FIFO_EMPTY), 32'd1);
    check("dis_counter", bus.TRIGGER_COUNTER, model_cnt);
    bus.TRIGGER_ENABLE = 1'b1;
    cyc(3);

    // Randomized mixture of modes, IDs and acknowledge delays.
    for (int k = 0; k < 14; k++) begin
      m = mode_t'($urandom_range(0, 3));
      do_trigger(m, 15'($urandom_range(0, 32767)), $urandom_range(0, 12));
      if (k == 7) tlu_reset_pulse();
    end

    cyc(5);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
